// File: rtl/pe_array_sched.sv
// PE array task scheduler: start/done collection, ping-pong switch,
// and group-by-group accumulation drain with a latency-matched tag stream.
module pe_array_sched #(
   parameter int PE_NUM    = 32,
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
   parameter int RD_LAT    = 2,
   localparam int GRP_NUM  = PE_NUM / 4,
   localparam int GW       = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              task_valid,
   output logic              task_ready,
   input  logic [PE_NUM-1:0] task_pe_mask,
   input  logic              task_drain,
   input  logic [ADDR_W-1:0] task_rd_last,
   output logic [PE_NUM-1:0] start,
   input  logic [PE_NUM-1:0] done,
   output logic [PE_NUM-1:0] switch_a,
   output logic [GW-1:0]     rd_sel,
   output logic [ADDR_W-1:0] abuf_rd_addr,
   output logic              rd_valid,
   output logic              rd_last,
   output logic [GW-1:0]     rd_grp,
   output logic              busy
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE, START, COMPUTE, SWITCH, DRAIN, FLUSH
   } state_e;

   state_e              state_q;
   logic [PE_NUM-1:0]   mask_q;
   logic [PE_NUM-1:0]   done_seen_q;
   logic [PE_NUM-1:0]   done_seen_d;
   logic [PE_NUM-1:0]   start_q;
   logic [PE_NUM-1:0]   switch_q;
   logic                drain_q;
   logic [ADDR_W-1:0]   rdl_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [GW-1:0]       grp_q;
   logic                issue_q;
   logic [CW-1:0]       flush_q;
   logic [RD_LAT-1:0]   vpipe_q;
   logic [RD_LAT-1:0]   lpipe_q;
   logic [GW-1:0]       gpipe_q [RD_LAT];

   logic [GRP_NUM-1:0]  act;
   logic [GW-1:0]       low_grp;
   logic [GW-1:0]       nxt_grp;
   logic                nxt_found;
   logic                last_rd;

   always_comb begin
      for (int g = 0; g < GRP_NUM; g++) begin
         act[g] = |mask_q[4*g +: 4];
      end
   end

   // Descending scan: the last hit is the lowest qualifying group.
   always_comb begin
      low_grp   = '0;
      nxt_grp   = '0;
      nxt_found = 1'b0;
      for (int g = GRP_NUM - 1; g >= 0; g--) begin
         if (act[g]) begin
            low_grp = GW'(g);
            if (g > int'(grp_q)) begin
               nxt_grp   = GW'(g);
               nxt_found = 1'b1;
            end
         end
      end
   end

   assign done_seen_d = done_seen_q | (done & mask_q);
   assign last_rd     = (addr_q == rdl_q) && !nxt_found;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         done_seen_q <= '0;
         start_q     <= '0;
         switch_q    <= '0;
         drain_q     <= 1'b0;
         rdl_q       <= '0;
         addr_q      <= '0;
         grp_q       <= '0;
         issue_q     <= 1'b0;
         flush_q     <= '0;
         vpipe_q     <= '0;
         lpipe_q     <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            gpipe_q[i] <= '0;
         end
      end else begin
         vpipe_q[0] <= issue_q;
         lpipe_q[0] <= issue_q & last_rd;
         gpipe_q[0] <= grp_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
            lpipe_q[i] <= lpipe_q[i-1];
            gpipe_q[i] <= gpipe_q[i-1];
         end
         unique case (state_q)
            IDLE: begin
               if (task_valid) begin
                  mask_q  <= task_pe_mask;
                  drain_q <= task_drain;
                  rdl_q   <= task_rd_last;
                  if (|task_pe_mask) begin
                     start_q <= task_pe_mask;
                     state_q <= START;
                  end
               end
            end
            START: begin
               start_q     <= '0;
               done_seen_q <= '0;
               state_q     <= COMPUTE;
            end
            COMPUTE: begin
               done_seen_q <= done_seen_d;
               if (done_seen_d == mask_q) begin
                  switch_q <= mask_q;
                  state_q  <= SWITCH;
               end
            end
            SWITCH: begin
               switch_q <= '0;
               if (drain_q) begin
                  grp_q   <= low_grp;
                  addr_q  <= '0;
                  issue_q <= 1'b1;
                  state_q <= DRAIN;
               end else begin
                  state_q <= IDLE;
               end
            end
            DRAIN: begin
               if (last_rd) begin
                  issue_q <= 1'b0;
                  grp_q   <= '0;
                  addr_q  <= '0;
                  flush_q <= '0;
                  state_q <= FLUSH;
               end else if (addr_q == rdl_q) begin
                  grp_q  <= nxt_grp;
                  addr_q <= '0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            FLUSH: begin
               if (flush_q == CW'(RD_LAT - 1)) begin
                  state_q <= IDLE;
               end else begin
                  flush_q <= flush_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign task_ready   = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign start        = start_q;
   assign switch_a     = switch_q;
   assign rd_sel       = grp_q;
   assign abuf_rd_addr = addr_q;
   assign rd_valid     = vpipe_q[RD_LAT-1];
   assign rd_last      = lpipe_q[RD_LAT-1];
   assign rd_grp       = gpipe_q[RD_LAT-1];

endmodule

// File: tb/tb_pe_array_sched.sv
// Bench for pe_array_sched: per-cycle observation log compared against
// a task-level timing model (start/switch/drain/tag windows).
module tb_pe_array_sched;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        task_valid = 1'b0;
   logic        task_ready;
   logic [31:0] task_pe_mask = '0;
   logic        task_drain = 1'b0;
   logic [7:0]  task_rd_last = '0;
   logic [31:0] start;
   logic [31:0] done = '0;
   logic [31:0] switch_a;
   logic [2:0]  rd_sel;
   logic [7:0]  abuf_rd_addr;
   logic        rd_valid;
   logic        rd_last;
   logic [2:0]  rd_grp;
   logic        busy;

   pe_array_sched #(.PE_NUM(32), .BUF_DEPTH(256), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .task_valid(task_valid), .task_ready(task_ready),
      .task_pe_mask(task_pe_mask), .task_drain(task_drain),
      .task_rd_last(task_rd_last), .start(start), .done(done),
      .switch_a(switch_a), .rd_sel(rd_sel), .abuf_rd_addr(abuf_rd_addr),
      .rd_valid(rd_valid), .rd_last(rd_last), .rd_grp(rd_grp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] st;
      logic [31:0] sw;
      logic        rv;
      logic        rl;
      logic [2:0]  rg;
      logic        busy;
      logic        rdy;
   } obs_t;

   typedef struct {
      int         c;
      obs_t       o;
      logic [2:0] rs;
      logic [7:0] ra;
   } snap_t;

   typedef struct {
      int          T;
      int          D;
      logic [31:0] m;
      bit          dr;
      int          rl;
   } tk_t;

   typedef struct {
      int          off;
      logic [31:0] b;
   } pl_t;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    spur = 0;
   snap_t snap[$];
   tk_t   tasks[$];
   pl_t   sched[$];
   snap_t mon_s;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      mon_s.c      = cyc;
      mon_s.o.st   = start;
      mon_s.o.sw   = switch_a;
      mon_s.o.rv   = rd_valid;
      mon_s.o.rl   = rd_last;
      mon_s.o.rg   = rd_valid ? rd_grp : 3'd0;
      mon_s.o.busy = busy;
      mon_s.o.rdy  = task_ready;
      mon_s.rs     = rd_sel;
      mon_s.ra     = abuf_rd_addr;
      snap.push_back(mon_s);
   end

   // Expected observation in cycle c given every task accepted so far.
   function automatic void model(input int c, output obs_t e,
                                 output bit care, output logic [2:0] es,
                                 output logic [7:0] ea);
      e = '0;
      e.rdy = 1'b1;
      care = 0;
      es = '0;
      ea = '0;
      foreach (tasks[i]) begin
         tk_t t;
         int  act[$];
         int  n, idle, k;
         t = tasks[i];
         if (t.m == 0) continue;
         for (int g = 0; g < 8; g++)
            if (t.m[4*g +: 4] != 0) act.push_back(g);
         n = t.dr ? act.size() * (t.rl + 1) : 0;
         idle = t.dr ? t.D + 2 + n + RD_LAT : t.D + 2;
         if (c == t.T + 1) e.st = t.m;
         if (c == t.D + 1) e.sw = t.m;
         if (c > t.T && c < idle) begin
            e.busy = 1'b1;
            e.rdy = 1'b0;
         end
         k = c - (t.D + 2);
         if (t.dr && k >= 0 && k < n) begin
            care = 1;
            es = 3'(act[k / (t.rl + 1)]);
            ea = 8'(k % (t.rl + 1));
         end
         k = c - (t.D + 2 + RD_LAT);
         if (t.dr && k >= 0 && k < n) begin
            e.rv = 1'b1;
            e.rl = (k == n - 1);
            e.rg = 3'(act[k / (t.rl + 1)]);
         end
      end
   endfunction

   // Presents one task and plays the done schedule until the scheduler idles.
   task automatic run(input logic [31:0] m, input bit dr, input logic [7:0] rl,
                      input bit now, output int T, output bit ok);
      int maxoff = 0;
      int c;
      foreach (sched[i]) if (sched[i].off > maxoff) maxoff = sched[i].off;
      if (!now) begin
         @(posedge clk);
         #1;
      end
      task_valid = 1'b1;
      task_pe_mask = m;
      task_drain = dr;
      task_rd_last = rl;
      T = cyc;
      ok = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         c = cyc;
         task_valid = spur && (c <= T + 3);
         if (task_valid) begin
            task_pe_mask = '1;
            task_drain = 1'b1;
            task_rd_last = 8'd7;
         end
         done = '0;
         foreach (sched[i]) if (T + sched[i].off == c) done |= sched[i].b;
         if (c > T + maxoff && !busy) begin
            ok = 1;
            break;
         end
      end
      task_valid = 1'b0;
      done = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (task_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", task_ready);
      end
      checks++;
      if ({start, switch_a, rd_sel, abuf_rd_addr, rd_valid, rd_last, rd_grp, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outs start=%h sw=%h sel=%0d addr=%0d rv=%b rl=%b grp=%0d busy=%b exp all 0",
                  start, switch_a, rd_sel, abuf_rd_addr, rd_valid, rd_last, rd_grp, busy);
      end
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic test_full_nodrain();
      int T, dly;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      snap.delete();
      tasks.delete();
      dly = $urandom_range(2, 8);
      sched = '{'{dly, 32'hFFFF_FFFF}};
      run(32'hFFFF_FFFF, 0, 8'd0, 0, T, ok);
      tasks.push_back('{T, T + dly, 32'hFFFF_FFFF, 0, 0});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_nodrain timeout busy=%b exp 0", busy);
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL full_nodrain c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_staggered();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      snap.delete();
      tasks.delete();
      sched = '{'{5, 32'h1}, '{6, 32'h100}, '{7, 32'h8}, '{9, 32'h6}};
      run(32'hF, 0, 8'd0, 0, T, ok);
      tasks.push_back('{T, T + 9, 32'hF, 0, 0});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL staggered timeout busy=%b exp 0", busy);
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL staggered c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_drain_skip();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      snap.delete();
      tasks.delete();
      sched = '{'{4, 32'h0000_00F0}, '{6, 32'h000F_0000}};
      run(32'h000F_00F0, 1, 8'd3, 0, T, ok);
      tasks.push_back('{T, T + 6, 32'h000F_00F0, 1, 3});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_skip timeout busy=%b exp 0", busy);
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL drain_skip c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_full_depth();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      snap.delete();
      tasks.delete();
      sched = '{'{3, 32'hF000_0000}};
      run(32'hF000_0000, 1, 8'd255, 0, T, ok);
      tasks.push_back('{T, T + 3, 32'hF000_0000, 1, 255});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_depth timeout busy=%b exp 0", busy);
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL full_depth c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_zero_and_busy();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      snap.delete();
      tasks.delete();
      sched.delete();
      run(32'h0, 1, 8'd5, 0, T, ok);
      tasks.push_back('{T, T, 32'h0, 1, 5});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL zero_mask timeout busy=%b exp 0", busy);
      end
      sched = '{'{4, 32'h0000_0F00}};
      spur = 1;
      run(32'h0000_0F00, 1, 8'd2, 0, T, ok);
      spur = 0;
      tasks.push_back('{T, T + 4, 32'h0000_0F00, 1, 2});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL busy_req timeout busy=%b exp 0", busy);
      end
      repeat (4) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL zero_busy c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_back_to_back();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      logic [31:0] m;
      bit dr;
      logic [7:0] rl;
      snap.delete();
      tasks.delete();
      for (int k = 0; k < 2; k++) begin
         m = $urandom | 32'h1;
         dr = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rl = 8'($urandom_range(0, 5));
         sched = '{'{3, m}};
         run(m, dr, rl, k == 1, T, ok);
         tasks.push_back('{T, T + 3, m, dr, int'(rl)});
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL b2b timeout task=%0d busy=%b exp 0", k, busy);
         end
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL b2b c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_random();
      int T, dly;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      logic [31:0] m, lo;
      bit dr;
      logic [7:0] rl;
      snap.delete();
      tasks.delete();
      for (int k = 0; k < 6; k++) begin
         m = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
         dr = 1'($urandom_range(0, 1));
         rl = 8'($urandom_range(0, 7));
         dly = $urandom_range(2, 6);
         lo = m & (~m + 32'h1);
         sched.delete();
         if (m != 0) begin
            // done in the start cycle must not count toward completion
            sched.push_back('{1, m});
            if (dly > 2)
               sched.push_back('{$urandom_range(2, dly - 1),
                                 (m & $urandom & ~lo) | (~m & $urandom)});
            sched.push_back('{dly, m});
         end
         run(m, dr, rl, 0, T, ok);
         tasks.push_back('{T, T + dly, m, dr, int'(rl)});
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL random timeout task=%0d busy=%b exp 0", k, busy);
         end
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL random c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int T;
      bit ok, care;
      obs_t e;
      logic [2:0] es;
      logic [7:0] ea;
      @(posedge clk);
      #1;
      task_valid = 1'b1;
      task_pe_mask = 32'h00F0_0000;
      task_drain = 1'b1;
      task_rd_last = 8'd30;
      T = cyc;
      @(posedge clk);
      #1;
      task_valid = 1'b0;
      while (cyc < T + 3) begin
         @(posedge clk);
         #1;
      end
      done = 32'h00F0_0000;
      @(posedge clk);
      #1;
      done = '0;
      while (cyc < T + 10) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_drain_busy got=%b exp=1", busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (task_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_ready got=%b exp=1", task_ready);
      end
      checks++;
      if ({start, switch_a, rd_sel, abuf_rd_addr, rd_valid, rd_last, rd_grp, busy} !== '0) begin
         failures++;
         $display("FAIL async_reset_outs start=%h sw=%h sel=%0d addr=%0d rv=%b rl=%b grp=%0d busy=%b exp all 0",
                  start, switch_a, rd_sel, abuf_rd_addr, rd_valid, rd_last, rd_grp, busy);
      end
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      snap.delete();
      tasks.delete();
      repeat (6) @(posedge clk);
      sched = '{'{2, 32'h0000_000F}};
      run(32'h0000_000F, 1, 8'd1, 0, T, ok);
      tasks.push_back('{T, T + 2, 32'h0000_000F, 1, 1});
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL after_reset timeout busy=%b exp 0", busy);
      end
      repeat (3) @(posedge clk);
      foreach (snap[i]) begin
         model(snap[i].c, e, care, es, ea);
         checks++;
         if (snap[i].o !== e || (care && {snap[i].rs, snap[i].ra} !== {es, ea})) begin
            failures++;
            $display("FAIL after_reset c=%0d got=%h/%h exp=%h/%h",
                     snap[i].c, snap[i].o, {snap[i].rs, snap[i].ra}, e, {es, ea});
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_nodrain();
      test_staggered();
      test_drain_skip();
      test_full_depth();
      test_zero_and_busy();
      test_back_to_back();
      test_random();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d exp finish earlier", cyc);
      $fatal(1, "watchdog");
   end

endmodule
